// File: rtl/logic_gate_pipe_if.sv
// rtl/logic_gate_pipe_if.sv - handshake bundle for the registered logic unit
// Purpose: groups the producer-side beat stream, the consumer-side result
// stream and the busy status of logic_gate_pipe into one interface.
// Ports (signals):
//   in_valid/in_ready      producer handshake
//   in_a/in_b              WIDTH-bit operands
//   in_op                  3-bit function select
//   in_last                final beat of an accumulate burst
//   out_valid/out_ready    consumer handshake
//   out_y                  WIDTH-bit result
//   out_zero               out_y == 0, registered alongside out_y
//   out_beats              CNT_W-bit saturating count of folded beats
//   busy                   accumulate burst in progress
// Modports: slave = the logic unit, master = the surrounding system.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic [CNT_W-1:0] out_beats;
  logic             busy;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_last, out_ready,
    output in_ready, out_valid, out_y, out_zero, out_beats, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_y, out_zero, out_beats, busy
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// rtl/logic_gate_pipe.sv - one-deep registered bitwise logic unit with burst accumulate
// Purpose: applies one of eight bitwise functions to two operands per beat.
// Ops 0-5 (AND, OR, XOR, NAND, NOR, XNOR) give one result per beat; ops 6/7
// (ACC_AND, ACC_OR) fold a burst terminated by in_last into one result.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   pipe  logic_gate_pipe_if.slave (beat stream in, result stream out, busy)
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            rst,
  logic_gate_pipe_if.slave pipe
);

  localparam logic [2:0] OP_ACC_AND = 3'd6;

  typedef enum logic {S_IDLE, S_ACCUM} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_y_q;
  logic             out_zero_q;
  logic [CNT_W-1:0] out_beats_q;

  logic             in_ready;
  logic             accept;
  logic             is_acc_op;
  logic [2:0]       eff_op;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_inc;
  logic             load;
  logic [WIDTH-1:0] load_y;
  logic [CNT_W-1:0] load_beats;

  // Readiness depends only on the output register, so a stalled consumer
  // freezes the accumulator rather than corrupting it.
  assign in_ready  = !out_valid_q || pipe.out_ready;
  assign accept    = pipe.in_valid && in_ready;
  assign is_acc_op = pipe.in_op[2] && pipe.in_op[1];
  // Inside a burst the latched op governs; in_op is only meaningful on beat one.
  assign eff_op    = (state_q == S_ACCUM) ? op_q : pipe.in_op;

  always_comb begin
    case (eff_op)
      3'd0:    term = pipe.in_a & pipe.in_b;
      3'd1:    term = pipe.in_a | pipe.in_b;
      3'd2:    term = pipe.in_a ^ pipe.in_b;
      3'd3:    term = ~(pipe.in_a & pipe.in_b);
      3'd4:    term = ~(pipe.in_a | pipe.in_b);
      3'd5:    term = ~(pipe.in_a ^ pipe.in_b);
      3'd6:    term = pipe.in_a & pipe.in_b;
      default: term = pipe.in_a | pipe.in_b;
    endcase
  end

  assign acc_upd = (op_q == OP_ACC_AND) ? (acc_q & term) : (acc_q | term);
  // The beat count sticks at all-ones; the accumulator keeps folding.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE) begin
      if (accept && is_acc_op && !pipe.in_last) begin
        state_d = S_ACCUM;
      end
    end else begin
      if (accept && pipe.in_last) begin
        state_d = S_IDLE;
      end
    end
  end

  // FSM outputs
  always_comb begin
    pipe.busy = (state_q == S_ACCUM);
  end

  // Datapath next-state: burst accumulator and result load selection
  always_comb begin
    acc_d      = acc_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    load_y     = term;
    load_beats = CNT_W'(1);
    if (accept) begin
      if (state_q == S_IDLE) begin
        if (is_acc_op && !pipe.in_last) begin
          acc_d = term;
          op_d  = pipe.in_op;
          cnt_d = CNT_W'(1);
        end else begin
          load = 1'b1;
        end
      end else begin
        acc_d = acc_upd;
        cnt_d = cnt_inc;
        if (pipe.in_last) begin
          load       = 1'b1;
          load_y     = acc_upd;
          load_beats = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      op_q  <= 3'd0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      op_q  <= op_d;
      cnt_q <= cnt_d;
    end
  end

  // Output register: load only happens on an accepted beat, which implies the
  // previous result is either absent or leaving on this same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_zero_q  <= 1'b0;
      out_beats_q <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_y_q     <= load_y;
      out_zero_q  <= (load_y == '0);
      out_beats_q <= load_beats;
    end else if (pipe.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign pipe.in_ready  = in_ready;
  assign pipe.out_valid = out_valid_q;
  assign pipe.out_y     = out_y_q;
  assign pipe.out_zero  = out_zero_q;
  assign pipe.out_beats = out_beats_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb/tb_logic_gate_pipe.sv - self-checking bench for logic_gate_pipe (CNT_W 4 and 2 side by side)
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(4)) bus ();
  logic_gate_pipe_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

  logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut  (.clk(clk), .rst(rst), .pipe(bus.slave));
  logic_gate_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .pipe(bus2.slave));

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_a      = bus.in_a;
  assign bus2.in_b      = bus.in_b;
  assign bus2.in_op     = bus.in_op;
  assign bus2.in_last   = bus.in_last;
  assign bus2.out_ready = bus.out_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct { logic [7:0] y; int beats; } res_t;
  res_t exp_q[$];
  logic [7:0] got_y[$];
  int got_beats[$];
  int got2_beats[$];
  int got_zero[$];
  int got_cyc[$];

  bit         m_burst = 0;
  int         m_op = 0;
  logic [7:0] m_acc = '0;
  int         m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] f(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return ~(a ^ b);
      6: return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  // Reference model and per-cycle comparison
  always @(negedge clk) begin : cmp
    bit pend;
    bit exp_rdy;
    logic [7:0] t;
    res_t r;
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_burst = 0;
    end else begin
      pend = (exp_q.size() != 0);
      chk("out_valid", bus.out_valid, pend);
      chk("out_valid2", bus2.out_valid, pend);
      chk("busy", bus.busy, m_burst);
      chk("busy2", bus2.busy, m_burst);
      exp_rdy = !pend || bus.out_ready;
      chk("in_ready", bus.in_ready, exp_rdy);
      chk("in_ready2", bus2.in_ready, exp_rdy);
      if (pend) begin
        chk("out_y", bus.out_y, exp_q[0].y);
        chk("out_y2", bus2.out_y, exp_q[0].y);
        chk("out_zero", bus.out_zero, exp_q[0].y == 8'h00);
        chk("out_zero2", bus2.out_zero, exp_q[0].y == 8'h00);
        chk("out_beats", bus.out_beats, sat(exp_q[0].beats, 15));
        chk("out_beats2", bus2.out_beats, sat(exp_q[0].beats, 3));
      end
      if (bus.out_valid && bus.out_ready) begin
        got_y.push_back(bus.out_y);
        got_beats.push_back(int'(bus.out_beats));
        got2_beats.push_back(int'(bus2.out_beats));
        got_zero.push_back(int'(bus.out_zero));
        got_cyc.push_back(cyc);
      end
      if (pend && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && exp_rdy) begin
        if (!m_burst) begin
          t = f(int'(bus.in_op), bus.in_a, bus.in_b);
          if (bus.in_op < 3'd6 || bus.in_last) begin
            r.y = t; r.beats = 1;
            exp_q.push_back(r);
          end else begin
            m_burst = 1; m_op = int'(bus.in_op); m_acc = t; m_cnt = 1;
          end
        end else begin
          t = f(m_op, bus.in_a, bus.in_b);
          m_acc = (m_op == 6) ? (m_acc & t) : (m_acc | t);
          m_cnt++;
          if (bus.in_last) begin
            r.y = m_acc; r.beats = m_cnt;
            exp_q.push_back(r);
            m_burst = 0;
          end
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic last);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0 want 1");
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input int idx, input logic [7:0] y, input int beats, input int beats2, input int zero);
    if (got_y.size() <= idx) begin
      n_cmp++;
      n_bad++;
      $display("FAIL lit_count[%0d]: got %0d results want more than %0d", idx, got_y.size(), idx);
    end else begin
      chk($sformatf("lit_y[%0d]", idx), got_y[idx], y);
      chk($sformatf("lit_beats[%0d]", idx), got_beats[idx], beats);
      chk($sformatf("lit_beats2[%0d]", idx), got2_beats[idx], beats2);
      chk($sformatf("lit_zero[%0d]", idx), got_zero[idx], zero);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    logic [7:0] exp6 [6];
    exp6 = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33};

    // Reset with garbage on the inputs
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_a = 8'h5A; bus.in_b = 8'hA5;
    bus.in_op = 3'd7; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_zero", bus.out_zero, 0);
    chk("rst_out_beats", bus.out_beats, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_out_valid2", bus2.out_valid, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Ops 0-5 back to back
    bus.out_ready = 1'b1;
    base = got_y.size();
    for (int i = 0; i < 6; i++) send(3'(i), 8'hF0, 8'h3C, 1'b0);
    idle(3);
    for (int i = 0; i < 6; i++) lit(base + i, exp6[i], 1, 1, 0);
    for (int i = 1; i < 6; i++) begin
      if (got_cyc.size() > base + i)
        chk($sformatf("consec[%0d]", i), got_cyc[base + i] - got_cyc[base + i - 1], 1);
    end

    // Backpressure
    base = got_y.size();
    bus.out_ready = 1'b0;
    send(3'd0, 8'hAA, 8'h0F, 1'b0);
    fork
      send(3'd1, 8'h11, 8'h22, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready", bus.in_ready, 0);
          chk("bp_hold_y", bus.out_y, 8'h0A);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(3);
    lit(base, 8'h0A, 1, 1, 0);
    lit(base + 1, 8'h33, 1, 1, 0);

    // ACC_AND burst
    base = got_y.size();
    send(3'd6, 8'hFF, 8'hFF, 1'b0);
    chk("acc_busy1", bus.busy, 1);
    send(3'd6, 8'hF7, 8'hFF, 1'b0);
    chk("acc_busy2", bus.busy, 1);
    send(3'd6, 8'hFF, 8'h7F, 1'b1);
    chk("acc_busy3", bus.busy, 0);
    idle(3);
    chk("acc_one_result", got_y.size() - base, 1);
    lit(base, 8'h77, 3, 3, 0);

    // ACC_OR burst with op changing mid-burst
    base = got_y.size();
    send(3'd7, 8'h01, 8'h00, 1'b0);
    send(3'd0, 8'h00, 8'h80, 1'b0);
    send(3'd0, 8'h00, 8'h00, 1'b1);
    idle(3);
    lit(base, 8'h81, 3, 3, 0);

    // Saturating beat count
    base = got_y.size();
    for (int i = 0; i < 5; i++) send(3'd6, 8'hFF, 8'hFF, (i == 4));
    idle(3);
    lit(base, 8'hFF, 5, 3, 0);

    // Reset mid-burst, then a single XOR beat
    base = got_y.size();
    send(3'd6, 8'h0F, 8'hFF, 1'b0);
    send(3'd6, 8'hFF, 8'hFF, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    chk("mid_rst_no_result", got_y.size() - base, 0);
    send(3'd2, 8'h0F, 8'hFF, 1'b1);
    idle(3);
    lit(base, 8'hF0, 1, 1, 0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_gate_pipe.md
Name: logic_gate_pipe

Overview:
- Parametrised, registered successor to the team's single-bit two-input gate.
- Applies one of eight bitwise logic functions to two WIDTH-bit operands per beat, behind valid/ready handshakes on both sides.
- Accumulate modes fold a multi-beat burst into a single result word.
- Sits between a producer stream and a consumer stream as a one-deep pipelined logic unit.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 4, width of the beat counter reported with each result (>=1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  3  function select; sampled on the first beat of a burst.
- in_last  in  1  marks the final beat of an accumulate burst; ignored for ops 0-5.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  WIDTH  result word.
- out_zero  out  1  out_y == 0.
- out_beats  out  CNT_W  number of beats folded into out_y, saturating.
- busy  out  1  high while in ACCUM state.

Behaviour:
- Reset (async, immediate): state=IDLE, out_valid=0, out_y=0, out_zero=0, out_beats=0, busy=0, accumulator=0, latched op=0.
- Reset mid-burst discards the partial accumulation; no result is emitted.
- Beat transfer occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready, in every state.
- Combinational term f(a,b) by op:
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR: bitwise on a, b.
  - 6 ACC_AND: term = a & b.
  - 7 ACC_OR: term = a | b.
- State IDLE, accepted beat with op 0-5:
  - Next edge: out_y = f(a,b), out_beats = 1, out_valid = 1.
  - Latency is one cycle; throughput is one beat per cycle while out_ready = 1.
- State IDLE, accepted beat with op 6/7 and in_last = 1:
  - Behaves as single-beat: out_y = term, out_beats = 1.
- State IDLE, accepted beat with op 6/7 and in_last = 0:
  - acc = term, latched op = in_op, count = 1, go to ACCUM, busy = 1.
  - No output is produced.
- State ACCUM:
  - in_op is ignored; the latched op applies.
  - Each accepted beat: count = min(count+1, 2^CNT_W-1). For ACC_AND, acc = acc & term. For ACC_OR, acc = acc | term.
  - Accepted beat with in_last = 1: next edge out_y = updated acc, out_beats = updated count, out_valid = 1, go to IDLE, busy = 0.
  - No accepted beat: hold all state.
- Output register:
  - While out_valid && !out_ready, out_y, out_zero and out_beats hold stable and in_ready = 0.
  - A new result may load on the same edge the old one is accepted, giving back-to-back outputs with no bubble.
  - out_valid clears only when the result is accepted and no new result loads.
- out_zero is registered together with out_y; it is never combinational from the inputs.
- Saturation: out_beats sticks at 2^CNT_W-1; accumulation still continues correctly.
- Stalls inside ACCUM do not affect acc because in_ready depends only on the output register.
- in_valid low: no state change except the output handshake.

Test Plan:
- Reset while in_valid = 1 with garbage inputs -> all outputs 0, in_ready = 1 after reset release.
- WIDTH = 8, ops 0-5 with a = 8'hF0, b = 8'h3C, out_ready = 1 -> out_y, one cycle later each:
  - AND 30, OR FC, XOR CC, NAND CF, NOR 03, XNOR 33.
  - out_beats = 1 for every op.
  - Six results on six consecutive cycles.
- Backpressure: op 0 result pending with out_ready = 0 for 3 cycles -> out_y held, in_ready = 0, no beat lost. Raising out_ready delivers the results in order.
- ACC_AND burst of beats (FF,FF), (F7,FF), (FF,7F) with last on beat 3 -> single result out_y = 77, out_beats = 3, busy high across the burst.
- ACC_OR burst of beats (01,00), (00,80), (00,00), last on beat 3; the op field changes to 0 mid-burst and is ignored -> out_y = 81, out_zero = 0.
- CNT_W = 2: ACC_AND burst of 5 beats of (FF,FF) -> out_beats = 3 (saturated), out_y = FF.
- Reset asserted after beat 2 of a 4-beat burst -> no output. A following single op 2 beat (0F,FF) -> out_y = F0, out_beats = 1.
